// File: rtl/seg16_pkg.sv
// Shared constants for the 16-segment bus: segment code table, widths, decoder FSM states.
package seg16_pkg;

  localparam int unsigned SEG_W = 16;
  localparam int unsigned NIB_W = 4;

  // Bit order: a1 a2 b c d1 d2 e f g1 g2 h i j k l m (bit 0 = segment 1 = a1).
  localparam logic [SEG_W-1:0] SEG_CODE [16] = '{
    16'h00FF, // 0
    16'h000C, // 1
    16'h0377, // 2
    16'h033F, // 3
    16'h038C, // 4
    16'h03BB, // 5
    16'h03FB, // 6
    16'h000F, // 7
    16'h03FF, // 8
    16'h03BF, // 9
    16'h03CF, // A
    16'h4A3F, // B
    16'h00F3, // C
    16'h483F, // D
    16'h01F3, // E
    16'h01C3  // F
  };

  typedef enum logic [1:0] {
    StSettle,
    StDecode,
    StHold
  } state_e;

  typedef struct packed {
    logic             hit;
    logic [NIB_W-1:0] idx;
  } lookup_t;

  function automatic lookup_t seg_lookup(input logic [SEG_W-1:0] pat);
    lookup_t r;
    r.hit = 1'b0;
    r.idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_CODE[i]) begin
        r.hit = 1'b1;
        r.idx = NIB_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg16_decoder_if.sv
// Segment bus in, decoded count and sequence-check status out.
interface seg16_decoder_if;
  import seg16_pkg::*;

  logic [SEG_W-1:0] seg;
  logic [NIB_W-1:0] nibble;
  logic             valid;
  logic             bad_code;
  logic             dir_up;
  logic             dir_valid;
  logic             step_err;
  logic [7:0]       err_count;

  modport master (
    output seg,
    input  nibble, valid, bad_code, dir_up, dir_valid, step_err, err_count
  );

  modport slave (
    input  seg,
    output nibble, valid, bad_code, dir_up, dir_valid, step_err, err_count
  );

endinterface

// File: rtl/seg16_stable_filter.sv
// Synchronizes the segment lines, applies optional inversion and flags a settled pattern.
module seg16_stable_filter
  import seg16_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEG_W-1:0] seg,
  output logic [SEG_W-1:0] s,
  output logic             stable
);

  localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

  logic [SEG_W-1:0] sync1_q, sync2_q;
  logic [7:0]       cnt_q, cnt_d;
  logic             change;

  // sync1 holds the value s takes next edge, so the count clears on the edge s changes.
  assign change = (sync1_q != sync2_q);
  assign s      = sync2_q ^ {SEG_W{ACTIVE_LOW}};
  assign stable = (cnt_d == StableMax);

  always_comb begin
    cnt_d = cnt_q;
    if (change) begin
      cnt_d = 8'd0;
    end else if (cnt_q != StableMax) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= 8'd0;
    end else begin
      sync1_q <= seg;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/seg16_decoder.sv
// Decodes settled segment patterns to a nibble and checks the count steps by +/-1.
module seg16_decoder
  import seg16_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  seg16_decoder_if.slave bus
);

  logic [SEG_W-1:0] s;
  logic             stable;

  seg16_stable_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .ACTIVE_LOW    (ACTIVE_LOW)
  ) u_filter (
    .clk    (clk),
    .reset  (reset),
    .seg    (bus.seg),
    .s      (s),
    .stable (stable)
  );

  state_e           state_q, state_d;
  logic [NIB_W-1:0] nibble_q, nibble_d;
  logic [NIB_W-1:0] prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic             valid_q, valid_d;
  logic             bad_q, bad_d;
  logic             step_q, step_d;
  logic             dir_up_q, dir_up_d;
  logic             dir_valid_q, dir_valid_d;
  logic [7:0]       err_q, err_d;
  lookup_t          lk;

  always_comb begin
    lk           = seg_lookup(s);
    state_d      = state_q;
    nibble_d     = nibble_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    valid_d      = 1'b0;
    bad_d        = 1'b0;
    step_d       = 1'b0;
    dir_up_d     = dir_up_q;
    dir_valid_d  = dir_valid_q;
    err_d        = err_q;

    unique case (state_q)
      StSettle: begin
        if (stable) state_d = StDecode;
      end
      StDecode: begin
        // A change during this cycle must re-settle rather than sit in hold.
        state_d = stable ? StHold : StSettle;
        if (lk.hit) begin
          valid_d      = 1'b1;
          nibble_d     = lk.idx;
          prev_d       = lk.idx;
          prev_valid_d = 1'b1;
          if (prev_valid_q) begin
            if (lk.idx == prev_q + 4'd1) begin
              dir_up_d    = 1'b1;
              dir_valid_d = 1'b1;
            end else if (lk.idx == prev_q - 4'd1) begin
              dir_up_d    = 1'b0;
              dir_valid_d = 1'b1;
            end else if (lk.idx != prev_q) begin
              step_d = 1'b1;
            end
          end
        end else begin
          bad_d = 1'b1;
        end
      end
      StHold: begin
        if (!stable) state_d = StSettle;
      end
      default: state_d = StSettle;
    endcase

    if ((bad_d || step_d) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StSettle;
      nibble_q     <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      bad_q        <= 1'b0;
      step_q       <= 1'b0;
      dir_up_q     <= 1'b0;
      dir_valid_q  <= 1'b0;
      err_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      nibble_q     <= nibble_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      valid_q      <= valid_d;
      bad_q        <= bad_d;
      step_q       <= step_d;
      dir_up_q     <= dir_up_d;
      dir_valid_q  <= dir_valid_d;
      err_q        <= err_d;
    end
  end

  assign bus.nibble    = nibble_q;
  assign bus.valid     = valid_q;
  assign bus.bad_code  = bad_q;
  assign bus.dir_up    = dir_up_q;
  assign bus.dir_valid = dir_valid_q;
  assign bus.step_err  = step_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_seg16_decoder.sv
// Directed bench for seg16_decoder: default polarity instance plus an active-low instance.
module tb_seg16_decoder;
  import seg16_pkg::*;

  logic clk;
  logic reset;
  logic reset2;

  seg16_decoder_if bus1 ();
  seg16_decoder_if bus2 ();

  seg16_decoder u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  seg16_decoder #(
    .STABLE_CYCLES (4),
    .ACTIVE_LOW    (1'b1)
  ) u_dut_al (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int n_valid = 0;
  int n_bad = 0;
  int n_step = 0;
  int n_valid2 = 0;

  // Strobe counters sample mid-cycle; stimulus runs 2 time units after each rising edge.
  always @(negedge clk) begin
    if (bus1.valid) n_valid++;
    if (bus1.bad_code) n_bad++;
    if (bus1.step_err) n_step++;
    if (bus2.valid) n_valid2++;
  end

  task automatic clear_counts();
    n_valid = 0;
    n_bad = 0;
    n_step = 0;
    n_valid2 = 0;
  endtask

  task automatic hold(input logic [15:0] p, input int n);
    bus1.seg = p;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    clear_counts();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({bus1.valid, bus1.bad_code, bus1.step_err, bus1.dir_up, bus1.dir_valid} !== 5'b0)
      $display("FAIL reset_strobes: got %b want 00000",
               {bus1.valid, bus1.bad_code, bus1.step_err, bus1.dir_up, bus1.dir_valid});
    else passed++;
    checks++;
    if (bus1.nibble !== 4'd0 || bus1.err_count !== 8'd0)
      $display("FAIL reset_values: nibble %0d err %0d want 0 0", bus1.nibble, bus1.err_count);
    else passed++;
    reset = 1'b0;
    clear_counts();
    hold(SEG_CODE[3], 20);
    checks++;
    if (n_valid !== 1) $display("FAIL first_valid_count: got %0d want 1", n_valid);
    else passed++;
    checks++;
    if (bus1.nibble !== 4'd3) $display("FAIL first_nibble: got %0d want 3", bus1.nibble);
    else passed++;
    checks++;
    if (bus1.dir_valid !== 1'b0 || bus1.err_count !== 8'd0)
      $display("FAIL first_no_dir: dir_valid %b err %0d want 0 0", bus1.dir_valid,
               bus1.err_count);
    else passed++;
  endtask

  task automatic test_latency();
    bus1.seg = SEG_CODE[4];
    repeat (6) @(posedge clk);
    #2;
    checks++;
    if (bus1.valid !== 1'b0) $display("FAIL latency_early: valid %b want 0", bus1.valid);
    else passed++;
    @(posedge clk);
    #2;
    checks++;
    if (bus1.valid !== 1'b1 || bus1.nibble !== 4'd4)
      $display("FAIL latency_valid: valid %b nibble %0d want 1 4", bus1.valid, bus1.nibble);
    else passed++;
    checks++;
    if (bus1.dir_up !== 1'b1 || bus1.dir_valid !== 1'b1)
      $display("FAIL latency_dir: dir_up %b dir_valid %b want 1 1", bus1.dir_up,
               bus1.dir_valid);
    else passed++;
    @(posedge clk);
    #2;
    checks++;
    if (bus1.valid !== 1'b0) $display("FAIL strobe_width: valid %b want 0", bus1.valid);
    else passed++;
  endtask

  task automatic test_wrap_up();
    bus1.seg = SEG_CODE[14];
    do_reset();
    hold(SEG_CODE[14], 10);
    hold(SEG_CODE[15], 10);
    checks++;
    if (bus1.dir_up !== 1'b1 || bus1.dir_valid !== 1'b1)
      $display("FAIL up_second_accept: dir_up %b dir_valid %b want 1 1", bus1.dir_up,
               bus1.dir_valid);
    else passed++;
    hold(SEG_CODE[0], 10);
    hold(SEG_CODE[1], 10);
    checks++;
    if (n_valid !== 4 || n_step !== 0)
      $display("FAIL up_counts: valid %0d step %0d want 4 0", n_valid, n_step);
    else passed++;
    checks++;
    if (bus1.nibble !== 4'd1 || bus1.dir_up !== 1'b1 || bus1.err_count !== 8'd0)
      $display("FAIL up_final: nibble %0d dir_up %b err %0d want 1 1 0", bus1.nibble,
               bus1.dir_up, bus1.err_count);
    else passed++;
  endtask

  task automatic test_wrap_down();
    clear_counts();
    hold(SEG_CODE[0], 10);
    hold(SEG_CODE[15], 10);
    checks++;
    if (bus1.dir_up !== 1'b0 || bus1.dir_valid !== 1'b1)
      $display("FAIL down_dir: dir_up %b dir_valid %b want 0 1", bus1.dir_up, bus1.dir_valid);
    else passed++;
    checks++;
    if (n_valid !== 2 || n_step !== 0 || bus1.err_count !== 8'd0 || bus1.nibble !== 4'hF)
      $display("FAIL down_counts: valid %0d step %0d err %0d nibble %0d want 2 0 0 15",
               n_valid, n_step, bus1.err_count, bus1.nibble);
    else passed++;
  endtask

  task automatic test_step_bad();
    bus1.seg = SEG_CODE[5];
    do_reset();
    hold(SEG_CODE[5], 10);
    hold(SEG_CODE[9], 10);
    checks++;
    if (n_step !== 1 || bus1.err_count !== 8'd1)
      $display("FAIL step_err: step %0d err %0d want 1 1", n_step, bus1.err_count);
    else passed++;
    checks++;
    if (bus1.nibble !== 4'd9 || bus1.dir_valid !== 1'b0)
      $display("FAIL step_state: nibble %0d dir_valid %b want 9 0", bus1.nibble,
               bus1.dir_valid);
    else passed++;
    hold(16'h0000, 10);
    checks++;
    if (n_bad !== 1 || bus1.err_count !== 8'd2 || bus1.nibble !== 4'd9)
      $display("FAIL bad_code: bad %0d err %0d nibble %0d want 1 2 9", n_bad,
               bus1.err_count, bus1.nibble);
    else passed++;
  endtask

  task automatic test_glitch_saturate();
    bus1.seg = SEG_CODE[2];
    do_reset();
    hold(SEG_CODE[2], 12);
    clear_counts();
    hold(SEG_CODE[7], 2);
    hold(SEG_CODE[2], 12);
    checks++;
    if (n_valid !== 1 || bus1.nibble !== 4'd2)
      $display("FAIL glitch_valid: valid %0d nibble %0d want 1 2", n_valid, bus1.nibble);
    else passed++;
    checks++;
    if (n_step !== 0 || n_bad !== 0 || bus1.err_count !== 8'd0)
      $display("FAIL glitch_errors: step %0d bad %0d err %0d want 0 0 0", n_step, n_bad,
               bus1.err_count);
    else passed++;
    for (int i = 0; i < 300; i++) begin
      hold(((i % 2) == 1) ? 16'hFFFF : 16'h0000, 8);
    end
    checks++;
    if (n_bad !== 300) $display("FAIL bad_strobes: got %0d want 300", n_bad);
    else passed++;
    checks++;
    if (bus1.err_count !== 8'd255)
      $display("FAIL err_saturate: got %0d want 255", bus1.err_count);
    else passed++;
  endtask

  task automatic test_active_low_reset();
    checks++;
    if (bus2.nibble !== 4'd5) $display("FAIL al_initial: nibble %0d want 5", bus2.nibble);
    else passed++;
    clear_counts();
    bus2.seg = ~SEG_CODE[6];
    repeat (6) @(posedge clk);
    #2;
    reset2 = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (n_valid2 !== 0 || bus2.valid !== 1'b0)
      $display("FAIL al_reset_no_valid: count %0d valid %b want 0 0", n_valid2, bus2.valid);
    else passed++;
    checks++;
    if (bus2.nibble !== 4'd0 || bus2.dir_valid !== 1'b0 || bus2.err_count !== 8'd0)
      $display("FAIL al_reset_clear: nibble %0d dir_valid %b err %0d want 0 0 0",
               bus2.nibble, bus2.dir_valid, bus2.err_count);
    else passed++;
    reset2 = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    checks++;
    if (n_valid2 !== 1 || bus2.nibble !== 4'd6 || bus2.dir_valid !== 1'b0)
      $display("FAIL al_after_reset: valid %0d nibble %0d dir_valid %b want 1 6 0",
               n_valid2, bus2.nibble, bus2.dir_valid);
    else passed++;
  endtask

  initial begin
    bus1.seg = SEG_CODE[3];
    bus2.seg = ~SEG_CODE[5];
    reset = 1'b1;
    reset2 = 1'b1;
    @(posedge clk);
    #2;
    reset2 = 1'b0;
    test_reset();
    test_latency();
    test_wrap_up();
    test_wrap_down();
    test_step_bad();
    test_glitch_saturate();
    test_active_low_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seg16_decoder.md
# seg16_decoder

Receive-side decoder for the 16-line segment bus driven by the LED counter display path. Samples the 16 segment lines, waits for a stable pattern, maps it back to the 4-bit count value, and infers count direction (up/down) from successive values. Sits in loopback/self-test logic next to the display driver, on the same board clock, checking that the displayed count sequence is legal.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a pattern is accepted; legal range 1..255.
- ACTIVE_LOW, 0: 1 = segment lines are active-low; input inverted after synchronization.

Ports:
- clk  in  1  board clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- seg  in  16  segment lines; seg[0] is segment 1, seg[15] is segment 16. Asynchronous to clk.
- nibble  out  4  last accepted decoded value.
- valid  out  1  one-cycle strobe: a new legal pattern was accepted; nibble updated the same cycle.
- bad_code  out  1  one-cycle strobe: stable pattern matches no table entry.
- dir_up  out  1  last inferred direction: 1 = up, 0 = down.
- dir_valid  out  1  high once a direction has been inferred since reset.
- step_err  out  1  one-cycle strobe: accepted value is neither prev+1 nor prev-1 (mod 16).
- err_count  out  8  bad_code + step_err events since reset, saturating at 255.

## Operation
- Input path: 2-flop synchronizer on seg, then optional inversion (ACTIVE_LOW); result is s.
- Stability counter: cleared to 0 when s differs from its previous-cycle value; otherwise increments, saturating at STABLE_CYCLES.
- FSM states: SETTLE, DECODE, HOLD.
  - SETTLE: waits until counter reaches STABLE_CYCLES -> DECODE.
  - DECODE (1 cycle): look up s in SEG_CODE[0..15]. Match -> accept (valid=1, nibble=index). No match -> bad_code=1. Then -> HOLD.
  - HOLD: stays while s unchanged; any change -> SETTLE. A pattern is therefore decoded exactly once per stable period, however long.
- Direction inference on accept (not on first accept after reset, which only records prev):
  - index == prev+1 mod 16 -> dir_up=1, dir_valid=1.
  - index == prev-1 mod 16 -> dir_up=0, dir_valid=1.
  - index == prev -> no direction update, no error (pattern left and returned).
  - otherwise -> step_err=1; dir_up/dir_valid unchanged.
  - prev updated to index on every accept.
- Wrap: F->0 is up, 0->F is down.
- bad_code patterns never update prev, nibble or direction.
- err_count increments by 1 per strobe (bad_code and step_err cannot fire in the same cycle); holds at 255.

## Timing
- Reset values: nibble=0, valid=0, bad_code=0, dir_up=0, dir_valid=0, step_err=0, err_count=0, state=SETTLE, counter=0, synchronizer=0, prev marked empty.
- Latency: seg stable from before edge E0 -> valid/bad_code high in the cycle after edge E0+STABLE_CYCLES+2 (default: after the 7th rising edge counting E0 as 1st... i.e. edge E0+6).
- step_err, valid and dir_up update in the same cycle.
- Glitch shorter than STABLE_CYCLES cycles: counter restarts, no strobe; if s returns to the held pattern it is re-decoded after settling (same value -> valid only, no error).
- Reset asserted mid-SETTLE/DECODE: no strobe in the reset cycle; all state cleared next edge; next accept treated as first after reset.

## Structure
- Package seg16_pkg: SEG_CODE[0..15] 16-bit constants (single table shared with the display-side encoder), SEG_W=16, NIB_W=4, FSM state enum.
- Sub-module seg16_stable_filter: synchronizer, ACTIVE_LOW inversion, stability counter; outputs s and a stable flag. FSM, lookup and direction logic in seg16_decoder.

## Test plan
- Reset, then hold SEG_CODE[3] 20 cycles -> exactly one valid, nibble=3, dir_valid=0, err_count=0.
- Sequence SEG_CODE[14],[15],[0],[1], each held 10 cycles -> four valids, dir_up=1 from second accept, no step_err (wrap up).
- Sequence [1],[0],[15] -> dir_up=0, dir_valid=1, no errors (wrap down).
- [5] then [9] -> step_err once, err_count=1, dir unchanged, nibble=9; then 16'h0000 (no table match) held -> bad_code once, err_count=2, nibble stays 9.
- [2] held, 2-cycle glitch to [7], back to [2] -> no strobe for 7; one valid, nibble=2, no errors; 300 bad patterns -> err_count=255.
- ACTIVE_LOW=1 with ~SEG_CODE[6]; reset asserted 1 cycle before expected valid -> no valid, outputs zero; after release, valid with nibble=6, dir_valid=0.
